sequenciador_regras_param: RTL and testbench

//  Parametrised rule sequencer for the type-2 fuzzy inference datapath; successor of the fixed 9-rule controller.
//  On a start request it latches the active-FOU mask of two inputs and walks every (MF_a, MF_b) pair.
//  It issues only pairs whose two MFs are both active, one per valid/ready handshake with the inference unit.

---
 rtl/fuzzy_ctrl_pkg.sv | 28 ++
 rtl/contador_pares_mf.sv | 53 +++++
 rtl/sequenciador_regras_param.sv | 156 +++++++++++++++
 tb/tb_sequenciador_regras_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fuzzy_ctrl_pkg
// Description : Shared state encoding and constant-width helper for the
//               type-2 fuzzy rule sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fuzzy_ctrl_pkg;

    // Sequencer state codes, also exported on the estado debug port
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_scan  = 3'd2;
    localparam logic [2:0] c_st_issue = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Ceiling log2, evaluated at elaboration time to size indices and counters
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fuzzy_ctrl_pkg
`default_nettype wire

// File: rtl/contador_pares_mf.sv
`default_nettype none
// ============================================================================
// Module      : contador_pares_mf
// Description : (a,b) membership-function pair counter, a-major / b-minor.
//               Holds at (N_MF-1, N_MF-1) instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_pares_mf
    import fuzzy_ctrl_pkg::*;
#(
    parameter int N_MF = 3,
    parameter int AB_W = clog2_f(N_MF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [AB_W-1:0] o_a,
    output logic [AB_W-1:0] o_b,
    output logic            o_last
);

    localparam logic [AB_W-1:0] c_max = AB_W'(N_MF - 1);

    logic [AB_W-1:0] r_a;
    logic [AB_W-1:0] r_b;

    // Pair counter: clear wins over increment; saturates at the last pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_clr) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_inc) begin
            if (r_b == c_max) begin
                if (r_a != c_max) begin
                    r_b <= '0;
                    r_a <= r_a + AB_W'(1);
                end
            end else begin
                r_b <= r_b + AB_W'(1);
            end
        end
    end

    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_last = (r_a == c_max) && (r_b == c_max);

endmodule : contador_pares_mf
`default_nettype wire

// File: rtl/sequenciador_regras_param.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_regras_param
// Description : Parametrised rule sequencer. Latches the active-FOU mask of
//               two inputs and issues every (MF_a, MF_b) pair whose MFs are
//               both active, one per valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_regras_param
    import fuzzy_ctrl_pkg::*;
#(
    parameter int N_MF   = 3,
    parameter int RULE_W = clog2_f(N_MF * N_MF),
    parameter int CNT_W  = clog2_f(N_MF * N_MF + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_regras,
    input  logic [2*N_MF-1:0]   fou_ativo,
    input  logic                rule_ready,
    output logic                reset_inf,
    output logic                rule_valid,
    output logic [RULE_W-1:0]   sequencia_regras,
    output logic [RULE_W-1:0]   idx_a,
    output logic [RULE_W-1:0]   idx_b,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    n_regras,
    output logic [2:0]          estado
);

    localparam int              AB_W  = clog2_f(N_MF);
    localparam logic [RULE_W-1:0] c_nmf = RULE_W'(N_MF);

    logic [2:0]         r_state;
    logic [N_MF-1:0]    r_mask_a;
    logic [N_MF-1:0]    r_mask_b;
    logic               r_reset_inf;
    logic               r_rule_valid;
    logic [RULE_W-1:0]  r_seq;
    logic [RULE_W-1:0]  r_idx_a;
    logic [RULE_W-1:0]  r_idx_b;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_n_regras;

    logic [AB_W-1:0]    w_a;
    logic [AB_W-1:0]    w_b;
    logic               w_last;
    logic               w_hit;
    logic               w_clr;
    logic               w_inc;
    logic               w_accept;
    logic [RULE_W-1:0]  w_index;

    // Candidate evaluation and pair-counter control
    assign w_hit    = r_mask_a[w_a] & r_mask_b[w_b];
    assign w_accept = (r_state == c_st_issue) && rule_ready;
    assign w_clr    = (r_state == c_st_idle) && en_regras;
    assign w_inc    = ((r_state == c_st_scan) && !w_hit && !w_last) ||
                      (w_accept && !w_last);
    assign w_index  = RULE_W'(w_a) * c_nmf + RULE_W'(w_b);

    contador_pares_mf #(
        .N_MF (N_MF),
        .AB_W (AB_W)
    ) u_contador (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_a    (w_a),
        .o_b    (w_b),
        .o_last (w_last)
    );

    // Sequencer FSM; every output is a register set on the transition into its state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_mask_a     <= '0;
            r_mask_b     <= '0;
            r_reset_inf  <= 1'b0;
            r_rule_valid <= 1'b0;
            r_seq        <= '0;
            r_idx_a      <= '0;
            r_idx_b      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_n_regras   <= '0;
        end else begin
            r_reset_inf <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (en_regras) begin
                        r_mask_a    <= fou_ativo[N_MF-1:0];
                        r_mask_b    <= fou_ativo[2*N_MF-1:N_MF];
                        r_n_regras  <= '0;
                        r_reset_inf <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_clear;
                    end
                end
                c_st_clear: begin
                    r_state <= c_st_scan;
                end
                c_st_scan: begin
                    if (w_hit) begin
                        r_rule_valid <= 1'b1;
                        r_seq        <= w_index;
                        r_idx_a      <= RULE_W'(w_a);
                        r_idx_b      <= RULE_W'(w_b);
                        r_state      <= c_st_issue;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_done;
                    end
                end
                c_st_issue: begin
                    if (rule_ready) begin
                        r_rule_valid <= 1'b0;
                        r_n_regras   <= r_n_regras + CNT_W'(1);
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_scan;
                        end
                    end
                end
                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_rule_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

    assign reset_inf        = r_reset_inf;
    assign rule_valid       = r_rule_valid;
    assign sequencia_regras = r_seq;
    assign idx_a            = r_idx_a;
    assign idx_b            = r_idx_b;
    assign busy             = r_busy;
    assign done             = r_done;
    assign n_regras         = r_n_regras;
    assign estado           = r_state;

endmodule : sequenciador_regras_param
`default_nettype wire

// File: tb/tb_sequenciador_regras_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequenciador_regras_param
// Description : Scoreboard bench for the rule sequencer, N_MF=3 and N_MF=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequenciador_regras_param;

    typedef struct {
        int idx;
        int a;
        int b;
    } rule_t;

    logic clk;
    logic rst;

    // N_MF = 3 instance
    logic       en3, rdy3;
    logic [5:0] fou3;
    logic       rinf3_o, valid3, busy3, done3;
    logic [3:0] seq3, ia3, ib3;
    logic [3:0] n3;
    logic [2:0] est3;

    // N_MF = 4 instance
    logic       en4, rdy4;
    logic [7:0] fou4;
    logic       rinf4_o, valid4, busy4, done4;
    logic [3:0] seq4, ia4, ib4;
    logic [4:0] n4;
    logic [2:0] est4;

    int checks   = 0;
    int failures = 0;
    int rinf3    = 0;
    rule_t exp3[$];
    rule_t exp4[$];
    int    cnt3[$];
    int    cnt4[$];
    rule_t r3, r4;

    sequenciador_regras_param #(.N_MF(3)) dut3 (
        .clk(clk), .rst(rst), .en_regras(en3), .fou_ativo(fou3), .rule_ready(rdy3),
        .reset_inf(rinf3_o), .rule_valid(valid3), .sequencia_regras(seq3),
        .idx_a(ia3), .idx_b(ib3), .busy(busy3), .done(done3),
        .n_regras(n3), .estado(est3)
    );

    sequenciador_regras_param #(.N_MF(4)) dut4 (
        .clk(clk), .rst(rst), .en_regras(en4), .fou_ativo(fou4), .rule_ready(rdy4),
        .reset_inf(rinf4_o), .rule_valid(valid4), .sequencia_regras(seq4),
        .idx_a(ia4), .idx_b(ib4), .busy(busy4), .done(done4),
        .n_regras(n4), .estado(est4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Reference model: enumerate all pairs, keep those with both MFs active
    task automatic model3(input logic [5:0] f);
        int k = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                if (f[a] && f[3 + b]) begin
                    exp3.push_back('{a * 3 + b, a, b});
                    k++;
                end
        cnt3.push_back(k);
    endtask

    task automatic model4(input logic [7:0] f);
        int k = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                if (f[a] && f[4 + b]) begin
                    exp4.push_back('{a * 4 + b, a, b});
                    k++;
                end
        cnt4.push_back(k);
    endtask

    // Monitors: an accepted handshake is visible at the negedge before the accepting edge
    always @(negedge clk) begin
        if (rst) begin
            if (valid3 && rdy3) begin
                if (exp3.size() == 0) chk("unexpected_rule3", 1, 0);
                else begin
                    r3 = exp3.pop_front();
                    chk("rule_idx3", int'(seq3), r3.idx);
                    chk("rule_a3", int'(ia3), r3.a);
                    chk("rule_b3", int'(ib3), r3.b);
                end
            end
            if (done3) begin
                if (cnt3.size() == 0) chk("unexpected_done3", 1, 0);
                else chk("n_regras3", int'(n3), cnt3.pop_front());
            end
            if (rinf3_o) rinf3++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (valid4 && rdy4) begin
                if (exp4.size() == 0) chk("unexpected_rule4", 1, 0);
                else begin
                    r4 = exp4.pop_front();
                    chk("rule_idx4", int'(seq4), r4.idx);
                    chk("rule_a4", int'(ia4), r4.a);
                    chk("rule_b4", int'(ib4), r4.b);
                end
            end
            if (done4) begin
                if (cnt4.size() == 0) chk("unexpected_done4", 1, 0);
                else chk("n_regras4", int'(n4), cnt4.pop_front());
            end
        end
    end

    task automatic start3(input logic [5:0] f);
        model3(f);
        @(posedge clk); #1;
        fou3 = f;
        en3  = 1'b1;
        @(posedge clk); #1;
        en3  = 1'b0;
    endtask

    task automatic wait_done3(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done3) break;
        end
        if (i == bound) chk("timeout_done3", 0, 1);
    endtask

    task automatic wait_valid3(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid3) break;
        end
        if (i == bound) chk("timeout_valid3", 0, 1);
    endtask

    // Sweep on the N_MF=4 instance with a randomly toggling ready
    task automatic sweep4(input logic [7:0] f);
        int i;
        model4(f);
        @(posedge clk); #1;
        fou4 = f;
        en4  = 1'b1;
        @(posedge clk); #1;
        en4  = 1'b0;
        for (i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rdy4 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done4) break;
        end
        if (i == 400) chk("timeout_done4", 0, 1);
    endtask

    initial begin
        int scans;
        int rbefore;
        int i;
        rst = 1'b0;
        en3 = 1'b0; rdy3 = 1'b0; fou3 = '0;
        en4 = 1'b0; rdy4 = 1'b0; fou4 = '0;

        // Reset state
        #12;
        chk("rst_valid", int'(valid3), 0);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(done3), 0);
        chk("rst_rinf", int'(rinf3_o), 0);
        chk("rst_estado", int'(est3), 0);
        chk("rst_n", int'(n3), 0);
        chk("rst_seq", int'(seq3), 0);
        chk("rst_busy4", int'(busy4), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: A=011, B=110, ready tied high -> rules 1,2,4,5
        rdy3 = 1'b1;
        start3(6'b110_011);
        @(negedge clk);
        chk("lat_rinf", int'(rinf3_o), 1);
        chk("lat_busy", int'(busy3), 1);
        chk("lat_estado_clear", int'(est3), 1);
        @(negedge clk);
        chk("rinf_one_cycle", int'(rinf3_o), 0);
        chk("lat_estado_scan", int'(est3), 2);
        wait_done3(60);
        @(negedge clk);
        chk("idle_after_done", int'(est3), 0);
        chk("busy_after_done", int'(busy3), 0);
        chk("n_holds", int'(n3), 4);

        // 2: empty mask -> 9 SCAN cycles, no rule, n_regras=0
        start3(6'b000_000);
        scans = 0;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (est3 == 3'd2) scans++;
            if (done3) break;
        end
        if (i == 40) chk("timeout_empty", 0, 1);
        chk("empty_scan_cycles", scans, 9);

        // 3: backpressure on rule 0
        rdy3 = 1'b0;
        start3(6'b001_001);
        wait_valid3(20);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", int'(valid3), 1);
            chk("bp_idx", int'(seq3), 0);
            chk("bp_estado", int'(est3), 3);
        end
        @(posedge clk); #1;
        rdy3 = 1'b1;
        wait_done3(30);

        // 4: start and mask changes mid-sweep are ignored
        rbefore = rinf3;
        start3(6'b101_111);
        repeat (3) @(posedge clk);
        #1;
        en3  = 1'b1;
        fou3 = 6'b000_000;
        @(posedge clk); #1;
        en3  = 1'b0;
        fou3 = 6'b111_111;
        wait_done3(60);
        chk("no_second_rinf", rinf3 - rbefore, 1);

        // 5: async reset during ISSUE, then a full sweep
        start3(6'b111_111);
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid3 && n3 >= 4'd2) break;
        end
        if (i == 60) chk("timeout_mid_sweep", 0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", int'(valid3), 0);
        chk("arst_estado", int'(est3), 0);
        chk("arst_busy", int'(busy3), 0);
        chk("arst_n", int'(n3), 0);
        chk("arst_seq", int'(seq3), 0);
        exp3.delete();
        cnt3.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        start3(6'b111_111);
        wait_done3(60);

        // 6: N_MF=4 all active with random ready, then random masks
        sweep4(8'hFF);
        for (int k = 0; k < 4; k++) sweep4(8'($urandom));

        repeat (3) @(negedge clk);
        chk("q3_empty", exp3.size() + cnt3.size(), 0);
        chk("q4_empty", exp4.size() + cnt4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_sequenciador_regras_param
`default_nettype wire
